// File: rtl/imem_loader_if.sv
// Write-side and stream-side signal bundle between the byte stream source,
// the loader and the instruction RAM write port.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  i_start;
  logic [7:0]            i_rx_data;
  logic                  i_rx_valid;
  logic                  o_we;
  logic [ADDR_WIDTH-1:0] o_waddr;
  logic [7:0]            o_wdata;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_full;
  logic [ADDR_WIDTH:0]   o_byte_count;

  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input  o_we, o_waddr, o_wdata, o_busy, o_done, o_full, o_byte_count
  );

  modport slave (
    input  i_start, i_rx_data, i_rx_valid,
    output o_we, o_waddr, o_wdata, o_busy, o_done, o_full, o_byte_count
  );
endinterface

// File: rtl/imem_loader.sv
// Streams received bytes into the instruction RAM from address 0 until an
// aligned HALT word arrives or the RAM is full.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         i_rst_n,
  imem_loader_if.slave bus
);
  localparam int unsigned          DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]  LAST_CNT = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]  CNT_ONE  = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  full_q, full_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  // Only the three earlier bytes of the group are stored; the fourth is the
  // incoming byte, so the full 32-bit word is formed at compare time.
  logic [23:0]           word_q, word_d;
  logic                  halt_hit, cap_hit;

  assign halt_hit = (cnt_q[1:0] == 2'b11) && ({bus.i_rx_data, word_q} == HALT_WORD);
  assign cap_hit  = (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    full_d  = full_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.i_start) begin
          state_d = S_LOAD;
          full_d  = 1'b0;
          cnt_d   = '0;
          word_d  = '0;
        end
      end
      S_LOAD: begin
        if (bus.i_rx_valid) begin
          we_d    = 1'b1;
          waddr_d = cnt_q[ADDR_WIDTH-1:0];
          wdata_d = bus.i_rx_data;
          cnt_d   = cnt_q + CNT_ONE;
          word_d  = {bus.i_rx_data, word_q[23:8]};
          if (halt_hit) begin
            state_d = S_DONE;
            full_d  = 1'b0;
          end else if (cap_hit) begin
            state_d = S_DONE;
            full_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      full_q  <= 1'b0;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  assign bus.o_we         = we_q;
  assign bus.o_waddr      = waddr_q;
  assign bus.o_wdata      = wdata_q;
  assign bus.o_busy       = (state_q == S_LOAD);
  assign bus.o_done       = (state_q == S_DONE);
  assign bus.o_full       = full_q;
  assign bus.o_byte_count = cnt_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed scenarios plus randomized loads checked
// against a byte-list reference model and a captured RAM image.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(8)) b8 ();
  imem_loader_if #(.ADDR_WIDTH(4)) b4 ();

  imem_loader #(.ADDR_WIDTH(8), .HALT_WORD(32'hFFFF_FFFF)) u8 (.clk(clk), .i_rst_n(rst_n), .bus(b8));
  imem_loader #(.ADDR_WIDTH(4), .HALT_WORD(32'hFFFF_FFFF)) u4 (.clk(clk), .i_rst_n(rst_n), .bus(b4));

  typedef struct packed {
    logic       we;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       full;
    logic [8:0] cnt;
  } obs_t;

  int total = 0;
  int bad   = 0;

  logic [7:0] ram8 [256];
  logic [7:0] ram4 [16];
  int wr8 = 0;
  int wr4 = 0;

  always @(posedge clk) begin
    if (b8.o_we === 1'b1) begin ram8[b8.o_waddr] <= b8.o_wdata; wr8 <= wr8 + 1; end
    if (b4.o_we === 1'b1) begin ram4[b4.o_waddr] <= b4.o_wdata; wr4 <= wr4 + 1; end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic snap(input int w, output obs_t o);
    if (w == 8) begin
      o.we = b8.o_we; o.waddr = b8.o_waddr; o.wdata = b8.o_wdata;
      o.busy = b8.o_busy; o.done = b8.o_done; o.full = b8.o_full; o.cnt = b8.o_byte_count;
    end else begin
      o.we = b4.o_we; o.waddr = {4'h0, b4.o_waddr}; o.wdata = b4.o_wdata;
      o.busy = b4.o_busy; o.done = b4.o_done; o.full = b4.o_full; o.cnt = {4'h0, b4.o_byte_count};
    end
  endtask

  // One clock of stimulus; returns outputs sampled just after the edge.
  task automatic step(input int w, input logic st, input logic v, input logic [7:0] d, output obs_t o);
    @(negedge clk);
    if (w == 8) begin b8.i_start = st; b8.i_rx_valid = v; b8.i_rx_data = d; end
    else        begin b4.i_start = st; b4.i_rx_valid = v; b4.i_rx_data = d; end
    @(posedge clk);
    #1;
    if (w == 8) begin b8.i_start = 1'b0; b8.i_rx_valid = 1'b0; end
    else        begin b4.i_start = 1'b0; b4.i_rx_valid = 1'b0; end
    snap(w, o);
  endtask

  // Reference: walk the byte list, stop on aligned HALT or when RAM is full.
  function automatic void ref_load(input logic [7:0] q[$], input int depth,
                                   output int nwr, output bit done, output bit full);
    nwr = 0; done = 1'b0; full = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      if (done) break;
      nwr++;
      if ((nwr % 4 == 0) && ({q[i], q[i-1], q[i-2], q[i-3]} == 32'hFFFF_FFFF)) done = 1'b1;
      else if (nwr == depth) begin done = 1'b1; full = 1'b1; end
    end
  endfunction

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o;
    b8.i_start = 0; b8.i_rx_valid = 0; b8.i_rx_data = 0;
    b4.i_start = 0; b4.i_rx_valid = 0; b4.i_rx_data = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    snap(8, o); total++; if (o !== '0) begin bad++; $display("FAIL reset_w8: got %h want 0", o); end
    snap(4, o); total++; if (o !== '0) begin bad++; $display("FAIL reset_w4: got %h want 0", o); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    obs_t o;
    logic [7:0] prog [8] = '{8'h13, 8'h00, 8'h10, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    step(8, 1, 0, 0, o);
    total++; if (o.busy !== 1'b1 || o.cnt !== 9'd0) begin bad++; $display("FAIL basic_start: busy=%b cnt=%0d want 1/0", o.busy, o.cnt); end
    for (int i = 0; i < 8; i++) begin
      step(8, 0, 1, prog[i], o);
      total++;
      if (o.we !== 1'b1 || o.waddr !== 8'(i) || o.wdata !== prog[i] || o.cnt !== 9'(i + 1)) begin
        bad++; $display("FAIL basic_write%0d: we=%b addr=%0d data=%h cnt=%0d want 1/%0d/%h/%0d",
                        i, o.we, o.waddr, o.wdata, o.cnt, i, prog[i], i + 1);
      end
    end
    total++; if (o.done !== 1'b1 || o.busy !== 1'b0 || o.full !== 1'b0) begin bad++; $display("FAIL basic_done: done=%b busy=%b full=%b want 1/0/0", o.done, o.busy, o.full); end
    step(8, 0, 0, 0, o);
    total++; if (o.we !== 1'b0 || o.waddr !== 8'd7 || o.wdata !== 8'hFF || o.cnt !== 9'd8) begin bad++; $display("FAIL basic_hold: we=%b addr=%0d data=%h cnt=%0d want 0/7/ff/8", o.we, o.waddr, o.wdata, o.cnt); end
  endtask

  task automatic test_misaligned();
    obs_t o;
    logic [7:0] prog [8] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    step(8, 1, 0, 0, o);
    for (int i = 0; i < 8; i++) step(8, 0, 1, prog[i], o);
    total++; if (o.busy !== 1'b1 || o.done !== 1'b0 || o.cnt !== 9'd8) begin bad++; $display("FAIL misaligned_nohalt: busy=%b done=%b cnt=%0d want 1/0/8", o.busy, o.done, o.cnt); end
    for (int i = 0; i < 4; i++) step(8, 0, 1, 8'hFF, o);
    total++; if (o.done !== 1'b1 || o.full !== 1'b0 || o.cnt !== 9'd12 || o.waddr !== 8'd11) begin bad++; $display("FAIL misaligned_halt: done=%b full=%b cnt=%0d addr=%0d want 1/0/12/11", o.done, o.full, o.cnt, o.waddr); end
  endtask

  task automatic test_capacity();
    obs_t o;
    int w0;
    step(4, 1, 0, 0, o);
    w0 = wr4;
    for (int i = 0; i < 16; i++) step(4, 0, 1, 8'hAA, o);
    total++; if (o.we !== 1'b1 || o.waddr !== 8'd15 || o.done !== 1'b1 || o.full !== 1'b1 || o.cnt !== 9'd16) begin
      bad++; $display("FAIL capacity_end: we=%b addr=%0d done=%b full=%b cnt=%0d want 1/15/1/1/16", o.we, o.waddr, o.done, o.full, o.cnt); end
    step(4, 0, 1, 8'h55, o);
    total++; if (o.we !== 1'b0 || o.cnt !== 9'd16 || o.done !== 1'b1) begin bad++; $display("FAIL capacity_17th: we=%b cnt=%0d done=%b want 0/16/1", o.we, o.cnt, o.done); end
    step(4, 0, 0, 0, o);
    total++; if (wr4 - w0 !== 16) begin bad++; $display("FAIL capacity_writes: got %0d want 16", wr4 - w0); end
  endtask

  task automatic test_halt_at_capacity();
    obs_t o;
    step(4, 1, 0, 0, o);
    for (int i = 0; i < 12; i++) step(4, 0, 1, 8'h00, o);
    for (int i = 0; i < 4; i++) step(4, 0, 1, 8'hFF, o);
    total++; if (o.done !== 1'b1 || o.full !== 1'b0 || o.cnt !== 9'd16 || o.waddr !== 8'd15) begin
      bad++; $display("FAIL halt_cap: done=%b full=%b cnt=%0d addr=%0d want 1/0/16/15", o.done, o.full, o.cnt, o.waddr); end
  endtask

  task automatic test_restart();
    obs_t o;
    step(4, 1, 1, 8'h77, o);
    total++; if (o.we !== 1'b0 || o.busy !== 1'b1 || o.done !== 1'b0 || o.cnt !== 9'd0 || o.full !== 1'b0) begin
      bad++; $display("FAIL restart_from_done: we=%b busy=%b done=%b cnt=%0d full=%b want 0/1/0/0/0", o.we, o.busy, o.done, o.cnt, o.full); end
    step(4, 0, 1, 8'h11, o);
    total++; if (o.we !== 1'b1 || o.waddr !== 8'd0 || o.wdata !== 8'h11) begin bad++; $display("FAIL restart_first: we=%b addr=%0d data=%h want 1/0/11", o.we, o.waddr, o.wdata); end
    step(4, 0, 1, 8'h22, o);
    step(4, 1, 1, 8'h33, o);
    total++; if (o.we !== 1'b1 || o.waddr !== 8'd2 || o.wdata !== 8'h33 || o.cnt !== 9'd3 || o.busy !== 1'b1) begin
      bad++; $display("FAIL start_in_load: we=%b addr=%0d data=%h cnt=%0d busy=%b want 1/2/33/3/1", o.we, o.waddr, o.wdata, o.cnt, o.busy); end
    pulse_reset();
  endtask

  task automatic test_reset_mid_load();
    obs_t o;
    step(8, 1, 0, 0, o);
    for (int i = 0; i < 3; i++) step(8, 0, 1, 8'(8'h40 + i), o);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    snap(8, o);
    total++; if (o !== '0) begin bad++; $display("FAIL reset_async: got %h want 0", o); end
    step(8, 0, 1, 8'h99, o);
    total++; if (o.we !== 1'b0) begin bad++; $display("FAIL reset_held_write: we=%b want 0", o.we); end
    @(negedge clk); rst_n = 1'b1;
    step(8, 0, 1, 8'h98, o);
    total++; if (o.we !== 1'b0 || o.busy !== 1'b0) begin bad++; $display("FAIL reset_idle_write: we=%b busy=%b want 0/0", o.we, o.busy); end
    step(8, 1, 0, 0, o);
    step(8, 0, 1, 8'h5A, o);
    total++; if (o.we !== 1'b1 || o.waddr !== 8'd0 || o.wdata !== 8'h5A || o.cnt !== 9'd1) begin
      bad++; $display("FAIL reset_reload: we=%b addr=%0d data=%h cnt=%0d want 1/0/5a/1", o.we, o.waddr, o.wdata, o.cnt); end
    pulse_reset();
  endtask

  task automatic test_random(input int w, input int loads, input int maxlen);
    obs_t o;
    logic [7:0] q[$];
    logic [7:0] b, got;
    int nwr, w0, wr_now, depth, len, ram_bad;
    bit done, full;
    depth = (w == 8) ? 256 : 16;
    for (int l = 0; l < loads; l++) begin
      q.delete();
      step(w, 1, 0, 0, o);
      w0 = (w == 8) ? wr8 : wr4;
      len = $urandom_range(4, maxlen);
      for (int i = 0; i < len; i++) begin
        b = ($urandom_range(0, 9) < 6) ? 8'hFF : 8'($urandom_range(0, 255));
        q.push_back(b);
        repeat ($urandom_range(0, 2)) step(w, 0, 0, 0, o);
        step(w, 0, 1, b, o);
      end
      step(w, 0, 0, 0, o);
      ref_load(q, depth, nwr, done, full);
      wr_now = (w == 8) ? wr8 : wr4;
      total++; if (o.cnt !== 9'(nwr) || o.done !== done || o.full !== full || o.busy !== !done) begin
        bad++; $display("FAIL rand_w%0d_l%0d_status: cnt=%0d done=%b full=%b busy=%b want %0d/%b/%b/%b",
                        w, l, o.cnt, o.done, o.full, o.busy, nwr, done, full, !done); end
      total++; if (wr_now - w0 !== nwr) begin bad++; $display("FAIL rand_w%0d_l%0d_writes: got %0d want %0d", w, l, wr_now - w0, nwr); end
      ram_bad = 0;
      for (int i = 0; i < nwr; i++) begin
        got = (w == 8) ? ram8[i] : ram4[i];
        if (got !== q[i]) ram_bad++;
      end
      total++; if (ram_bad != 0) begin bad++; $display("FAIL rand_w%0d_l%0d_ram: %0d bad bytes want 0", w, l, ram_bad); end
      if (!done) pulse_reset();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_misaligned();
    pulse_reset();
    test_capacity();
    test_halt_at_capacity();
    test_restart();
    test_reset_mid_load();
    test_random(8, 8, 48);
    test_random(4, 10, 24);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
